// File: rtl/snake_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snake_move_scheduler
// Description : Game-level controller for the snake head-position datapath.
//               Runs the IDLE/START/RUN/OVER state machine, the move tick
//               timer and the committed travel direction. Issues one-cycle
//               move pulses, a restart pulse, and keeps the score and speed.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_move_scheduler #(
  parameter int CNT_W     = 26,
  parameter int TICK_INIT = 25000000,
  parameter int TICK_STEP = 1000000,
  parameter int TICK_MIN  = 5000000,
  parameter int SCORE_MAX = 99
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       btn_L,
  input  logic       btn_R,
  input  logic       btn_U,
  input  logic       btn_D,
  input  logic       start,
  input  logic       hit_score,
  input  logic       gameover,
  output logic       move_L,
  output logic       move_R,
  output logic       move_U,
  output logic       move_D,
  output logic       pos_reset,
  output logic       grow,
  output logic [6:0] score,
  output logic       running,
  output logic       over
);

  localparam int C_SUM_MIN_STEP = TICK_MIN + TICK_STEP;
  localparam logic [CNT_W-1:0] C_TICK_INIT   = TICK_INIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_TICK_STEP   = TICK_STEP[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_TICK_MIN    = TICK_MIN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_MIN_STEP    = C_SUM_MIN_STEP[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]       C_SCORE_MAX   = SCORE_MAX[6:0];

  // Direction encoding: opposite directions differ only in bit 0.
  localparam logic [1:0] C_DIR_L = 2'd0;
  localparam logic [1:0] C_DIR_R = 2'd1;
  localparam logic [1:0] C_DIR_U = 2'd2;
  localparam logic [1:0] C_DIR_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_prev;       // {start, U, D, L, R} previous levels
  logic [4:0]       w_keys;
  logic [4:0]       w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [1:0]       r_dir;
  logic [1:0]       r_req_dir;
  logic             r_sample;
  logic [3:0]       r_move;       // one-hot {D, U, R, L}
  logic             r_grow;
  logic [6:0]       r_score;
  logic             w_tick;
  logic             w_req_valid;
  logic [1:0]       w_req_dir;

  assign w_keys = {start, btn_U, btn_D, btn_L, btn_R};
  assign w_edge = w_keys & ~r_prev;

  // State register.
  always_ff @(posedge Clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, move tick and direction-request decode.
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    w_req_valid  = 1'b0;
    w_req_dir    = C_DIR_L;
    case (r_state)
      S_IDLE:  if (w_edge[4]) w_state_next = S_START;
      S_START: w_state_next = S_RUN;
      S_RUN: begin
        if (gameover)          w_state_next = S_OVER;
        else if (r_cnt == '0)  w_tick = 1'b1;
      end
      S_OVER:  if (w_edge[4]) w_state_next = S_START;
      default: w_state_next = S_IDLE;
    endcase
    // Highest-priority pressed key wins; a reversal is dropped, not demoted.
    if      (w_edge[3]) w_req_dir = C_DIR_U;
    else if (w_edge[2]) w_req_dir = C_DIR_D;
    else if (w_edge[1]) w_req_dir = C_DIR_L;
    else                w_req_dir = C_DIR_R;
    w_req_valid = (r_state == S_RUN) && (|w_edge[3:0]) &&
                  (w_req_dir != (r_dir ^ 2'b01));
  end

  // Datapath: timer, direction, move pulses, score and speed.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_prev    <= '0;
      r_cnt     <= '0;
      r_period  <= C_TICK_INIT;
      r_dir     <= C_DIR_L;
      r_req_dir <= C_DIR_L;
      r_sample  <= 1'b0;
      r_move    <= '0;
      r_grow    <= 1'b0;
      r_score   <= '0;
    end else begin
      r_prev   <= w_keys;
      r_move   <= '0;
      r_grow   <= 1'b0;
      r_sample <= 1'b0;
      if (r_state == S_START) begin
        r_score   <= '0;
        r_period  <= C_TICK_INIT;
        r_dir     <= C_DIR_L;
        r_req_dir <= C_DIR_L;
        r_cnt     <= C_TICK_INIT - C_CNT_ONE;
      end else if (r_state == S_RUN && !gameover) begin
        if (w_tick) begin
          r_move   <= 4'b0001 << r_req_dir;
          r_dir    <= r_req_dir;
          r_cnt    <= r_period - C_CNT_ONE;
          r_sample <= 1'b1;
        end else begin
          r_cnt <= r_cnt - C_CNT_ONE;
        end
      end
      if (w_req_valid) r_req_dir <= w_req_dir;
      // Sample cycle follows a tick, so it never overlaps START.
      if (r_sample && hit_score) begin
        r_grow <= 1'b1;
        if (r_score < C_SCORE_MAX) r_score <= r_score + 7'd1;
        if (r_period < C_MIN_STEP) r_period <= C_TICK_MIN;
        else                       r_period <= r_period - C_TICK_STEP;
      end
    end
  end

  assign move_L    = r_move[0];
  assign move_R    = r_move[1];
  assign move_U    = r_move[2];
  assign move_D    = r_move[3];
  assign grow      = r_grow;
  assign score     = r_score;
  assign pos_reset = (r_state == S_START);
  assign running   = (r_state == S_RUN);
  assign over      = (r_state == S_OVER);

endmodule
`default_nettype wire
